// File: rtl/ultrasound_time_pkg.sv
// Shared types for the ultrasound system-time counter.
// State encoding and synchronizer latency used by the counter core.
package ultrasound_time_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Cycles from a sync_in rise to the cycle the edge pulse is acted on.
  localparam int unsigned SYNC_LAT = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a registered rising-edge pulse.
// level_o is the synchronized level; pulse_o is high for one cycle.
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic pulse_o
);

  logic [2:0] sh_q;
  logic       pulse_q;

  // Shift the async input through the synchronizer and edge register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      sh_q    <= {sh_q[1:0], d_i};
      pulse_q <= sh_q[1] & ~sh_q[2];
    end
  end

  assign level_o = sh_q[1];
  assign pulse_o = pulse_q;

endmodule

// File: rtl/ultrasound_time_cnt_sync.sv
// Ultrasound system-time and phase counter aligned to EtherCAT SYNC0.
// Define ULTRASOUND_DRIFT_COMP_EN to trim drift at every later SYNC0 edge.
module ultrasound_time_cnt_sync
  import ultrasound_time_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 9,
  parameter int unsigned SYNC_PERIOD = 20480,
  parameter int unsigned RESYNC_TH   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 sync_in,
  input  logic                 sync_set,
  input  logic [63:0]          sync_time,
  output logic [63:0]          sys_time,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 update,
  output logic                 synced,
  output logic                 sync_err
);

  logic lock_s;
  logic lock_pulse_unused;
  logic sync_edge;
  logic sync_lvl_unused;

  sync_edge_detect u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (locked),
    .level_o (lock_s),
    .pulse_o (lock_pulse_unused)
  );

  sync_edge_detect u_sync0 (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (sync_in),
    .level_o (sync_lvl_unused),
    .pulse_o (sync_edge)
  );

  state_e      state_q, state_d;
  logic [63:0] time_q, time_d;
  logic [63:0] base_q, base_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic [1:0]  step;
  logic        load;

`ifdef ULTRASOUND_DRIFT_COMP_EN
  localparam int unsigned ADJ_W = $clog2(RESYNC_TH + 1) + 2;
  localparam logic signed [64:0] TH_P = $signed(65'(RESYNC_TH));
  localparam logic signed [64:0] TH_N = -TH_P;

  logic [63:0]        exp_q, exp_d;
  logic [ADJ_W-1:0]   adj_q, adj_d;
  logic signed [64:0] err;
  logic               adj_pos;
  logic               adj_neg;

  assign adj_neg = adj_q[ADJ_W-1];
  assign adj_pos = (adj_q != '0) && !adj_q[ADJ_W-1];
`else
  localparam int unsigned unused_cfg = SYNC_PERIOD + RESYNC_TH;
`endif

  // Next-state: lock loss beats sync_set, which beats the SYNC0 edge.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    err_d   = err_q;
    step    = 2'd1;
    load    = 1'b0;
`ifdef ULTRASOUND_DRIFT_COMP_EN
    exp_d   = exp_q;
    adj_d   = adj_q;
    err     = $signed({1'b0, time_q + 64'd1})
            - $signed({1'b0, exp_q});
    if (state_q == RUN) begin
      unique case (1'b1)
        adj_pos: begin
          step  = 2'd0;
          adj_d = adj_q - ADJ_W'(1);
        end
        adj_neg: begin
          step  = 2'd2;
          adj_d = adj_q + ADJ_W'(1);
        end
        default: step = 2'd1;
      endcase
    end
`endif
    if (!lock_s) begin
      state_d = IDLE;
      step    = 2'd0;
`ifdef ULTRASOUND_DRIFT_COMP_EN
      adj_d   = adj_q;
`endif
    end else if (sync_set) begin
      state_d = ARMED;
      base_d  = sync_time;
      err_d   = 1'b0;
    end else if (sync_edge && state_q == ARMED) begin
      state_d = RUN;
      load    = 1'b1;
`ifdef ULTRASOUND_DRIFT_COMP_EN
      exp_d   = base_q + 64'(SYNC_LAT) + 64'(SYNC_PERIOD);
      adj_d   = '0;
`endif
    end
`ifdef ULTRASOUND_DRIFT_COMP_EN
    else if (sync_edge && state_q == RUN) begin
      exp_d = exp_q + 64'(SYNC_PERIOD);
      if (err <= TH_P && err >= TH_N) begin
        adj_d = err[ADJ_W-1:0];
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
`endif
    time_d = load ? base_q + 64'(SYNC_LAT)
                  : time_q + {62'd0, step};
    upd_d  = !load &&
             (time_d[CNT_WIDTH-1:0] < time_q[CNT_WIDTH-1:0]);
  end

  // Counter, state and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      base_q  <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      base_q  <= base_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

`ifdef ULTRASOUND_DRIFT_COMP_EN
  // Expected time of the next edge and pending drift trim.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q <= '0;
      adj_q <= '0;
    end else begin
      exp_q <= exp_d;
      adj_q <= adj_d;
    end
  end
`endif

  assign sys_time = time_q;
  assign cnt      = time_q[CNT_WIDTH-1:0];
  assign update   = upd_q;
  assign synced   = (state_q == RUN);
  assign sync_err = err_q;

endmodule

// File: tb/tb_ultrasound_time_cnt_sync.sv
// Randomized bench for ultrasound_time_cnt_sync.
// Compares every cycle against a tick-level behavioural model.
module tb_ultrasound_time_cnt_sync;

  localparam int CW = 9;
  localparam int P  = 4096;
  localparam int TH = 64;
`ifdef ULTRASOUND_DRIFT_COMP_EN
  localparam bit DRIFT = 1'b1;
`else
  localparam bit DRIFT = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;

  logic          clk;
  logic          reset_n;
  logic          locked;
  logic          sync_in;
  logic          sync_set;
  logic [63:0]   sync_time;
  logic [63:0]   sys_time;
  logic [CW-1:0] cnt;
  logic          update;
  logic          synced;
  logic          sync_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ultrasound_time_cnt_sync #(
    .CNT_WIDTH   (CW),
    .SYNC_PERIOD (P),
    .RESYNC_TH   (TH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .locked    (locked),
    .sync_in   (sync_in),
    .sync_set  (sync_set),
    .sync_time (sync_time),
    .sys_time  (sys_time),
    .cnt       (cnt),
    .update    (update),
    .synced    (synced),
    .sync_err  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  logic [63:0] m_time, m_base, m_exp;
  int          m_adj;
  int          m_state;
  bit          m_err;
  bit          m_upd;
  logic [3:0]  sh;
  logic [1:0]  lh;

  always @(posedge clk or negedge reset_n) begin : model
    logic        lk, ed, ld;
    int          st, stp, na;
    logic [63:0] nb, ne, nt;
    bit          nerr;
    longint      e;
    if (!reset_n) begin
      m_time  <= '0;
      m_base  <= '0;
      m_exp   <= '0;
      m_adj   <= 0;
      m_state <= M_IDLE;
      m_err   <= 1'b0;
      m_upd   <= 1'b0;
      sh      <= '0;
      lh      <= '0;
    end else begin
      // lock seen 2 samples late, edge acted on 3 samples after rise
      lk   = lh[1];
      ed   = sh[2] & ~sh[3];
      st   = m_state;
      stp  = 1;
      na   = m_adj;
      nb   = m_base;
      ne   = m_exp;
      nerr = m_err;
      ld   = 1'b0;
      if (DRIFT && m_state == M_RUN && m_adj != 0) begin
        stp = (m_adj > 0) ? 0 : 2;
        na  = (m_adj > 0) ? m_adj - 1 : m_adj + 1;
      end
      if (!lk) begin
        st  = M_IDLE;
        stp = 0;
        na  = m_adj;
      end else if (sync_set) begin
        st   = M_ARMED;
        nb   = sync_time;
        nerr = 1'b0;
      end else if (ed && m_state == M_ARMED) begin
        st = M_RUN;
        ld = 1'b1;
        ne = m_base + 3 + P;
        na = 0;
      end else if (DRIFT && ed && m_state == M_RUN) begin
        e  = longint'(m_time + 1 - m_exp);
        ne = m_exp + P;
        if (e >= -TH && e <= TH) begin
          na = int'(e);
        end else begin
          st   = M_IDLE;
          nerr = 1'b1;
        end
      end
      nt = ld ? m_base + 3 : m_time + stp;
      m_upd   <= !ld && ((nt % 512) < (m_time % 512));
      m_time  <= nt;
      m_base  <= nb;
      m_exp   <= ne;
      m_adj   <= na;
      m_state <= st;
      m_err   <= nerr;
      sh      <= {sh[2:0], sync_in};
      lh      <= {lh[0], locked};
    end
  end

  logic [76:0] dut_v, exp_v;
  assign dut_v = {sys_time, cnt, update, synced, sync_err};
  assign exp_v = {m_time, m_time[CW-1:0], m_upd,
                  (m_state == M_RUN), m_err};

  task automatic test_reset();
    bit seen;
    seen      = 1'b0;
    reset_n   = 1'b0;
    locked    = 1'b1;
    sync_in   = 1'b0;
    sync_set  = 1'b0;
    sync_time = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (dut_v !== '0) begin
      failures++;
      $display("FAIL reset dut=%h want=0", dut_v);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL reset_run cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (update && !seen) begin
        seen = 1'b1;
        checks++;
        if (sys_time !== 64'd512 || cnt !== '0) begin
          failures++;
          $display("FAIL first_update time=%0d cnt=%0d want 512/0",
                   sys_time, cnt);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL first_update never pulsed");
    end
  endtask

  task automatic test_align();
    for (int i = 0; i <= 4 + P; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL align cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 8) begin
        checks++;
        if (sys_time !== 64'h1003 || cnt !== 9'd3 || synced !== 1'b1) begin
          failures++;
          $display("FAIL align_load time=%h cnt=%0d synced=%b want 1003/3/1",
                   sys_time, cnt, synced);
        end
      end
      if (i == 0) begin
        sync_time = 64'h1000;
        sync_set  = 1'b1;
      end
      if (i == 1) sync_set = 1'b0;
      if (i == 4) sync_in = 1'b1;
      if (i == 12) sync_in = 1'b0;
    end
  endtask

  task automatic test_drift();
    int r;
    int offs[4];
    r = int'($urandom_range(60, 1));
    if ($urandom_range(1, 0) == 1) r = -r;
    offs = '{2, -2, r, -r};
    foreach (offs[k]) begin
      sync_in = 1'b1;
      for (int i = 0; i < P + offs[k]; i++) begin
        @(negedge clk);
        checks++;
        if (dut_v !== exp_v) begin
          failures++;
          $display("FAIL drift%0d cyc=%0d dut=%h model=%h",
                   k, cyc, dut_v, exp_v);
        end
        if (i == 8) sync_in = 1'b0;
      end
      checks++;
      if (synced !== 1'b1) begin
        failures++;
        $display("FAIL drift_synced%0d got=%b want=1", k, synced);
      end
    end
  endtask

  task automatic test_wrap();
    int nupd;
    nupd = 0;
    sync_in = 1'b1;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL wrap_arm cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 8) sync_in = 1'b0;
      if (i == 20) begin
        sync_time = {32'($urandom), 23'($urandom), 9'h1FE};
        sync_set  = 1'b1;
      end
      if (i == 21) sync_set = 1'b0;
    end
    sync_in = 1'b1;
    for (int i = 0; i < P - 4; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL wrap_load cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 8) sync_in = 1'b0;
    end
    sync_in = 1'b1;
    for (int i = 0; i < P + 4; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL wrap_step cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i < 16 && update) nupd++;
      if (i == 8) sync_in = 1'b0;
    end
    checks++;
    if (nupd !== 1) begin
      failures++;
      $display("FAIL wrap_updates got=%0d want=1", nupd);
    end
  endtask

  task automatic test_early();
    sync_in = 1'b1;
    for (int i = 0; i < P - 100; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL early_pre cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 8) sync_in = 1'b0;
    end
    sync_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL early cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 6) begin
        checks++;
        if (synced !== !DRIFT || sync_err !== DRIFT) begin
          failures++;
          $display("FAIL early_drop synced=%b err=%b want %b/%b",
                   synced, sync_err, !DRIFT, DRIFT);
        end
      end
      if (i == 13) begin
        checks++;
        if (sync_err !== 1'b0 || synced !== 1'b0) begin
          failures++;
          $display("FAIL early_clear synced=%b err=%b want 0/0",
                   synced, sync_err);
        end
      end
      if (i == 8) sync_in = 1'b0;
      if (i == 10) sync_set = 1'b1;
      if (i == 11) sync_set = 1'b0;
    end
  endtask

  task automatic test_lock();
    sync_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL lock cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 50) begin
        checks++;
        if (synced !== 1'b1) begin
          failures++;
          $display("FAIL lock_run synced=%b want=1", synced);
        end
      end
      if (i == 108 || i == 130) begin
        checks++;
        if (synced !== 1'b0 || sync_err !== 1'b0) begin
          failures++;
          $display("FAIL lock_idle%0d synced=%b err=%b want 0/0",
                   i, synced, sync_err);
        end
      end
      if (i == 8) sync_in = 1'b0;
      if (i == 100) locked = 1'b0;
      if (i == 102) sync_in = 1'b1;
      if (i == 104) begin
        sync_time = {$urandom, $urandom};
        sync_set  = 1'b1;
      end
      if (i == 105) sync_set = 1'b0;
      if (i == 110) locked = 1'b1;
      if (i == 112) sync_in = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] t;
    t = {$urandom, $urandom};
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL b2b cyc=%0d dut=%h model=%h",
                 cyc, dut_v, exp_v);
      end
      if (i == 12) begin
        checks++;
        if (synced !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ignore synced=%b want=0", synced);
        end
      end
      if (i == 24) begin
        checks++;
        if (sys_time !== t + 64'd3 || synced !== 1'b1) begin
          failures++;
          $display("FAIL b2b_load time=%h synced=%b want %h/1",
                   sys_time, synced, t + 64'd3);
        end
      end
      if (i == 0) begin
        sync_time = t;
        sync_set  = 1'b1;
      end
      if (i == 1) sync_set = 1'b0;
      if (i == 5) sync_in = 1'b1;
      if (i == 8) sync_set = 1'b1;
      if (i == 9) sync_set = 1'b0;
      if (i == 13) sync_in = 1'b0;
      if (i == 20) sync_in = 1'b1;
      if (i == 28) sync_in = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_align();
    test_drift();
    test_wrap();
    test_early();
    test_lock();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
